// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 operation codes,
// the decoder's funct7 match value and the unit's state encoding.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: yields |val| at accept and applies the
// result sign at finalize.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the RV32M extension.
// One shared 2*XLEN shift register holds the product accumulator or {rem, quot}.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: start is taken in IDLE or DONE only (ignored while busy, no
    // queueing); done is a one-cycle pulse with result held until the next done.
    md_state_e         state;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        op_q;
    logic              sign_q;
    logic [CW-1:0]     cnt;

    logic            a_signed, b_signed, sa, sb, sign_in, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, fast_val;

    assign a_signed = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                      (funct3 == MD_DIV)  || (funct3 == MD_REM);
    assign b_signed = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    assign sa       = a_signed & op_a[XLEN-1];
    assign sb       = b_signed & op_b[XLEN-1];
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                      (op_a == MIN_INT) && (op_b == '1);

    muldiv_signfix #(.W(XLEN)) u_abs_a (.val(op_a), .neg(sa), .res(abs_a));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.val(op_b), .neg(sb), .res(abs_b));

    // Quotient and high products carry sign(a)^sign(b); remainder and MULHSU carry sign(a).
    always_comb begin
        sign_in = 1'b0;
        case (funct3)
            MD_MULH, MD_DIV:   sign_in = sa ^ sb;
            MD_MULHSU, MD_REM: sign_in = sa;
            default:           sign_in = 1'b0;
        endcase
    end

    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = funct3[1] ? op_a : '1;
        else if (div_ovf)
            fast_val = funct3[1] ? '0 : MIN_INT;
    end

    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

    // rem_sh keeps the bit shifted out of rem, since 2*rem can exceed XLEN bits.
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_sub  = rem_sh[XLEN-1:0] - opnd_q;
    assign div_next = rem_ge ? {rem_sub, acc[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    assign acc_step = op_q[2] ? div_next : mul_next;

    logic [XLEN-1:0]   div_sel, fin_res;
    logic [2*XLEN-1:0] fin_in, fin_out;

    assign div_sel = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    assign fin_in  = op_q[2] ? {{XLEN{1'b0}}, div_sel} : acc_step;

    muldiv_signfix #(.W(2*XLEN)) u_fin (.val(fin_in), .neg(sign_q), .res(fin_out));

    assign fin_res = ((op_q == MD_MUL) || op_q[2]) ? fin_out[XLEN-1:0]
                                                   : fin_out[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            opnd_q <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        op_q   <= funct3;
                        sign_q <= sign_in;
                        cnt    <= CW'(XLEN);
                        if (funct3[2]) begin
                            acc    <= {{XLEN{1'b0}}, abs_a};
                            opnd_q <= abs_b;
                        end else begin
                            acc    <= {{XLEN{1'b0}}, abs_b};
                            opnd_q <= abs_a;
                        end
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= fast_val;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= fin_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
